// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   state_t       : fetch FSM states (BOOT, RUN, HALT)
//   fetch_entry_t : one instruction buffer entry {pc, instr}
//   XLEN, PC_INC  : datapath width and sequential fetch stride
package fetch_unit_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: control inputs, instruction memory port and decode-side
// valid/ready handshake.
//   slave  : seen by fetch_unit
//   master : seen by the environment driving fetch_unit
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic            fetch_en;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            rom_en;
    logic [30:0]     rom_addr;
    logic [XLEN-1:0] rom_instr;
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] if_instr;

    modport slave (
        input  fetch_en, redirect_valid, redirect_pc, rom_instr, if_ready,
        output rom_en, rom_addr, if_valid, if_pc, if_instr
    );

    modport master (
        output fetch_en, redirect_valid, redirect_pc, rom_instr, if_ready,
        input  rom_en, rom_addr, if_valid, if_pc, if_instr
    );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO used as the fetch instruction buffer.
//   clk, rst_n : clock, async active-low reset (pointers/count only)
//   push/data  : write an entry at the clock edge
//   pop        : drop the head entry at the clock edge
//   flush      : empty the buffer; wins over push and pop
//   head_data  : current head entry (meaningless while count == 0)
//   count      : number of held entries
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 64,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [W-1:0]  head_data,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    // Storage is not reset; the top masks outputs while empty.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: BOOT/RUN/HALT FSM, program counter and a small
// instruction buffer feeding decode.
//   clk, rst_n : clock, async active-low reset
//   bus        : fetch_unit_if.slave (control, ROM port, decode handshake)
// RESET_PC is the first fetch address; FIFO_DEPTH is a power of two, 2..8.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_unit_if.slave   bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    state_t          state, state_nxt;
    logic [XLEN-1:0] pc;
    logic [CW-1:0]   count;
    logic            pop, fetch;
    fetch_entry_t    push_entry, head;

    assign pop = bus.if_valid && bus.if_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= BOOT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        fetch     = 1'b0;
        case (state)
            BOOT: state_nxt = bus.fetch_en ? RUN : HALT;
            RUN: begin
                if (!bus.fetch_en) state_nxt = HALT;
                // A full buffer still takes a fetch when its head leaves now.
                fetch = !bus.redirect_valid && ((count != DEPTH_C) || pop);
            end
            HALT: if (bus.fetch_en) state_nxt = RUN;
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  pc <= RESET_PC;
        else if (bus.redirect_valid) pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
        else if (fetch)              pc <= pc + PC_INC;
    end

    assign push_entry = '{pc: pc, instr: bus.rom_instr};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(fetch_entry_t))
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fetch),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (bus.redirect_valid),
        .head_data (head),
        .count     (count)
    );

    assign bus.rom_en   = fetch;
    assign bus.rom_addr = pc[30:0];
    assign bus.if_valid = (count != '0);
    assign bus.if_pc    = bus.if_valid ? head.pc    : '0;
    assign bus.if_instr = bus.if_valid ? head.instr : '0;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: boot stream, back-pressure, redirect,
// PC wrap, halt/drain and asynchronous reset.
module tb_fetch_unit;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: two known words at 0 and 4, zero elsewhere.
    assign bus.rom_instr = (bus.rom_addr == 31'h0) ? 32'h8000_0337 :
                           (bus.rom_addr == 31'h4) ? 32'h0003_03E7 : 32'h0;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Hold reset across an edge, release just after an edge; DUT is in BOOT.
    task automatic start(input logic en, input logic rdy);
        rst_n = 1'b0;
        bus.fetch_en = en;
        bus.if_ready = rdy;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.fetch_en = 1'b1;
        bus.if_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        cyc();
        checks++; if (bus.rom_en !== 1'b0) begin errors++; $display("FAIL reset_rom_en got %b want 0", bus.rom_en); end
        checks++; if (bus.rom_addr !== 31'h0) begin errors++; $display("FAIL reset_rom_addr got %h want 0", bus.rom_addr); end
        checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL reset_if_valid got %b want 0", bus.if_valid); end
        checks++; if (bus.if_pc !== 32'h0) begin errors++; $display("FAIL reset_if_pc got %h want 0", bus.if_pc); end
        checks++; if (bus.if_instr !== 32'h0) begin errors++; $display("FAIL reset_if_instr got %h want 0", bus.if_instr); end
    endtask

    task automatic test_stream();
        start(1'b1, 1'b1);
        cyc(); // BOOT -> RUN
        checks++; if (bus.rom_en !== 1'b1 || bus.rom_addr !== 31'h0) begin errors++; $display("FAIL stream_first_fetch got en=%b addr=%h want en=1 addr=0", bus.rom_en, bus.rom_addr); end
        cyc();
        checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0 || bus.if_instr !== 32'h8000_0337) begin errors++; $display("FAIL stream_head0 got v=%b pc=%h instr=%h want v=1 pc=0 instr=80000337", bus.if_valid, bus.if_pc, bus.if_instr); end
        cyc();
        checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h4 || bus.if_instr !== 32'h0003_03E7) begin errors++; $display("FAIL stream_head4 got v=%b pc=%h instr=%h want v=1 pc=4 instr=000303e7", bus.if_valid, bus.if_pc, bus.if_instr); end
        cyc();
        checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h8 || bus.if_instr !== 32'h0) begin errors++; $display("FAIL stream_head8 got v=%b pc=%h instr=%h want v=1 pc=8 instr=0", bus.if_valid, bus.if_pc, bus.if_instr); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc;
        start(1'b1, 1'b0);
        cyc(); // BOOT -> RUN
        cyc(); // push pc 0
        cyc(); // push pc 4, buffer full
        checks++; if (bus.rom_en !== 1'b0) begin errors++; $display("FAIL bp_full_rom_en got %b want 0", bus.rom_en); end
        cyc();
        cyc();
        checks++; if (bus.rom_en !== 1'b0 || bus.if_pc !== 32'h0 || bus.if_valid !== 1'b1) begin errors++; $display("FAIL bp_hold got en=%b v=%b pc=%h want en=0 v=1 pc=0", bus.rom_en, bus.if_valid, bus.if_pc); end
        bus.if_ready = 1'b1;
        #1;
        checks++; if (bus.rom_en !== 1'b1 || bus.rom_addr !== 31'h8) begin errors++; $display("FAIL bp_full_pop_fetch got en=%b addr=%h want en=1 addr=8", bus.rom_en, bus.rom_addr); end
        exp_pc = 32'h0;
        for (int i = 0; i < 6; i++) begin
            checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== exp_pc) begin errors++; $display("FAIL bp_drain[%0d] got v=%b pc=%h want v=1 pc=%h", i, bus.if_valid, bus.if_pc, exp_pc); end
            exp_pc = exp_pc + 32'd4;
            cyc();
        end
    endtask

    task automatic test_redirect();
        start(1'b1, 1'b0);
        cyc();
        cyc();
        cyc(); // full with pc 0, 4
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0000_0106;
        #1;
        checks++; if (bus.rom_en !== 1'b0) begin errors++; $display("FAIL redir_no_fetch got %b want 0", bus.rom_en); end
        cyc();
        bus.redirect_valid = 1'b0;
        #1;
        checks++; if (bus.if_valid !== 1'b0 || bus.rom_addr !== 31'h104 || bus.rom_en !== 1'b1) begin errors++; $display("FAIL redir_flush got v=%b addr=%h en=%b want v=0 addr=104 en=1", bus.if_valid, bus.rom_addr, bus.rom_en); end
        bus.if_ready = 1'b1;
        cyc();
        checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h104) begin errors++; $display("FAIL redir_head got v=%b pc=%h want v=1 pc=104", bus.if_valid, bus.if_pc); end
        cyc();
        checks++; if (bus.if_pc !== 32'h108) begin errors++; $display("FAIL redir_next got pc=%h want 108", bus.if_pc); end
    endtask

    task automatic test_wrap();
        // Two redirects back to back: the second one wins.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0000_0400;
        cyc();
        bus.redirect_pc = 32'hFFFF_FFFE;
        #1;
        checks++; if (bus.rom_en !== 1'b0) begin errors++; $display("FAIL wrap_consec_no_fetch got %b want 0", bus.rom_en); end
        cyc();
        bus.redirect_valid = 1'b0;
        #1;
        checks++; if (bus.rom_addr !== 31'h7FFF_FFFC || bus.if_valid !== 1'b0) begin errors++; $display("FAIL wrap_addr got addr=%h v=%b want addr=7ffffffc v=0", bus.rom_addr, bus.if_valid); end
        cyc();
        checks++; if (bus.if_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc0 got %h want fffffffc", bus.if_pc); end
        cyc();
        checks++; if (bus.if_pc !== 32'h0 || bus.if_instr !== 32'h8000_0337) begin errors++; $display("FAIL wrap_pc1 got pc=%h instr=%h want pc=0 instr=80000337", bus.if_pc, bus.if_instr); end
        cyc();
        checks++; if (bus.if_pc !== 32'h4) begin errors++; $display("FAIL wrap_pc2 got %h want 4", bus.if_pc); end
    endtask

    task automatic test_halt();
        start(1'b1, 1'b0);
        cyc();
        cyc();
        cyc(); // full with pc 0, 4; pc = 8
        bus.fetch_en = 1'b0;
        cyc(); // RUN -> HALT
        bus.if_ready = 1'b1;
        #1;
        checks++; if (bus.rom_en !== 1'b0 || bus.if_pc !== 32'h0) begin errors++; $display("FAIL halt_hold got en=%b pc=%h want en=0 pc=0", bus.rom_en, bus.if_pc); end
        cyc();
        checks++; if (bus.rom_en !== 1'b0 || bus.if_valid !== 1'b1 || bus.if_pc !== 32'h4) begin errors++; $display("FAIL halt_drain got en=%b v=%b pc=%h want en=0 v=1 pc=4", bus.rom_en, bus.if_valid, bus.if_pc); end
        cyc();
        checks++; if (bus.if_valid !== 1'b0 || bus.rom_en !== 1'b0) begin errors++; $display("FAIL halt_empty got v=%b en=%b want v=0 en=0", bus.if_valid, bus.rom_en); end
        bus.fetch_en = 1'b1;
        cyc(); // HALT -> RUN
        checks++; if (bus.rom_en !== 1'b1 || bus.rom_addr !== 31'h8) begin errors++; $display("FAIL halt_resume got en=%b addr=%h want en=1 addr=8", bus.rom_en, bus.rom_addr); end
    endtask

    task automatic test_async_reset();
        start(1'b1, 1'b1);
        cyc();
        cyc();
        cyc();
        cyc(); // streaming, pc well past 0
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.rom_en !== 1'b0 || bus.rom_addr !== 31'h0 || bus.if_valid !== 1'b0 || bus.if_pc !== 32'h0 || bus.if_instr !== 32'h0) begin errors++; $display("FAIL async_rst got en=%b addr=%h v=%b pc=%h instr=%h want all 0", bus.rom_en, bus.rom_addr, bus.if_valid, bus.if_pc, bus.if_instr); end
        cyc();
        rst_n = 1'b1;
        #1;
        checks++; if (bus.rom_en !== 1'b0) begin errors++; $display("FAIL async_boot_no_fetch got %b want 0", bus.rom_en); end
        cyc(); // BOOT -> RUN
        checks++; if (bus.rom_en !== 1'b1 || bus.rom_addr !== 31'h0) begin errors++; $display("FAIL async_restart got en=%b addr=%h want en=1 addr=0", bus.rom_en, bus.rom_addr); end
        cyc();
        checks++; if (bus.if_pc !== 32'h0 || bus.if_instr !== 32'h8000_0337) begin errors++; $display("FAIL async_head got pc=%h instr=%h want pc=0 instr=80000337", bus.if_pc, bus.if_instr); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.fetch_en = 1'b0;
        bus.if_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_halt();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning: first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 2, meaning: instruction buffer entries, power of two, 2..8.
REQ-003 clk  input  1  meaning: single clock, all state on rising edge.
REQ-004 rst_n  input  1  meaning: reset, asynchronous assert, active-low.
REQ-005 fetch_en  input  1  meaning: fetch permitted while high.
REQ-006 redirect_valid  input  1  meaning: control-flow change request.
REQ-007 redirect_pc  input  32  meaning: new fetch address.
REQ-008 rom_en  output  1  meaning: instruction memory read enable.
REQ-009 rom_addr  output  31  meaning: memory byte address, equals pc[30:0].
REQ-010 rom_instr  input  32  meaning: memory read data, combinational on rom_addr, same cycle.
REQ-011 if_valid  output  1  meaning: buffer head holds a valid instruction.
REQ-012 if_ready  input  1  meaning: downstream decode accepts head.
REQ-013 if_pc  output  32  meaning: address of head instruction.
REQ-014 if_instr  output  32  meaning: head instruction word.

Function
REQ-015 FSM states: BOOT, RUN, HALT; BOOT lasts exactly one cycle after reset release, then goes to RUN if fetch_en is high, else HALT.
REQ-016 RUN goes to HALT when fetch_en is low; HALT goes to RUN when fetch_en is high; redirect_valid never changes state.
REQ-017 rom_en is high only in RUN and only when the buffer can accept an entry this cycle (count < FIFO_DEPTH, or full with a pop this cycle), and redirect_valid is low.
REQ-018 While rom_en is high, {pc, rom_instr} is pushed at the clock edge and pc advances by 4; pc wraps from 32'hFFFF_FFFC to 32'h0000_0000.
REQ-019 Push-to-if_valid latency is one cycle; a fetch issued in cycle N is visible at the head in cycle N+1 when the buffer was empty.
REQ-020 Pop occurs when if_valid and if_ready are both high; simultaneous push and pop leaves count unchanged.
REQ-021 if_valid equals (count != 0); if_pc/if_instr show the head entry and remain stable while if_valid is high and if_ready is low.
REQ-022 redirect_valid in any state flushes all buffer entries, suppresses the push that cycle, and loads pc with {redirect_pc[31:2], 2'b00}; if_valid is low the next cycle.
REQ-023 Redirect has priority over a simultaneous pop; the popped entry is still accepted downstream that cycle.
REQ-024 Consecutive redirects: the last one wins; no fetch occurs in any cycle with redirect_valid high.
REQ-025 rom_addr drives pc[30:0] in every state; pc[31] is kept for if_pc only.
REQ-026 A fetch_en drop does not flush the buffer; buffered entries still drain.

Reset
REQ-027 Asynchronous assertion of rst_n low sets state to BOOT, pc to RESET_PC, and count and pointers to 0, including mid-operation.
REQ-028 Reset values: rom_en 0, rom_addr RESET_PC[30:0], if_valid 0, if_pc 0, if_instr 0.
REQ-029 Buffer data storage needs no reset; outputs are masked to 0 while empty.

Structure
REQ-030 A shared package holds the FSM state typedef, the PC increment constant (4), and the XLEN=32 width constant.
REQ-031 The buffer is a sub-module named fetch_fifo (synchronous FIFO with push/pop/flush, count output); fetch_unit holds the FSM and PC.

Verification
REQ-032 Reset release with fetch_en=1, ROM model returning 80000337 at 0 and 000303E7 at 4, if_ready=1 -> if_pc 0/if_instr 80000337, then if_pc 4/if_instr 000303E7 on consecutive cycles, then zeros from pc 8.
REQ-033 if_ready=0 for 5 cycles after start -> rom_en drops after 2 pushes, head stays pc 0; raising if_ready -> in-order drain with no lost or duplicated pc.
REQ-034 redirect_valid with redirect_pc=32'h0000_0106 while buffer full -> next cycle if_valid=0, rom_addr=0x104, following head if_pc=0x104.
REQ-035 Redirect to 32'hFFFF_FFFC -> fetched pcs FFFF_FFFC, 0000_0000, 0000_0004.
REQ-036 fetch_en toggled low mid-stream -> HALT, rom_en=0, buffer drains; rst_n pulsed low mid-fetch -> all outputs at reset values immediately, restart at RESET_PC.
